// File: rtl/ps2_key_sequencer_pkg.sv
// Shared scan-code constants, sequencer state and event types for the
// PS/2 key sequencer.
package ps2_pkg;

  // Scan-code bytes with special meaning to the sequencer.
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_BATERR = 8'hFC;

  // Prefix-sequencing states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } seq_state_t;

  // What a non-prefix byte does to the key table and event queue.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_MAKE,
    ACT_BREAK,
    ACT_CLEAR
  } seq_act_t;

  // One decoded key event as delivered to the consumer.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
  } key_evt_t;

  // True for the two prefix bytes that never terminate a sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte-in / event-out bus of the PS/2 key sequencer.
// master: the side feeding scan bytes and consuming events.
// slave : the sequencer itself.
interface ps2_key_sequencer_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_make;

  modport master (
    output byte_valid, byte_data, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_make
  );

  modport slave (
    input  byte_valid, byte_data, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_make
  );

endinterface

// File: rtl/ps2_key_sequencer_evt_fifo.sv
// First-word fall-through queue of key events. A pop in the same cycle as
// a push on a full queue frees the slot, so the push is accepted. The head
// reads as all-zero while the queue is empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     Clk,
  input  logic     Reset,
  input  logic     push,
  input  key_evt_t din,
  input  logic     pop,
  output key_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  key_evt_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? key_evt_t'('0) : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end
  end

  // Event storage write port.
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately not reset; entries are only read once
    // count says they were written, so a reset would buy nothing.
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 key sequencer: turns the raw scan-byte stream into make/break events,
// tracks currently held keys in a small slot table, and queues events for a
// valid/ready consumer.
// Optional build macro PS2_TYPEMATIC_EN: when defined, a make for a key that
// is already held is re-queued as an auto-repeat; otherwise it is dropped.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int SLOTS  = 6,
  parameter int QDEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  ps2_key_sequencer_if.slave         bus,
  output logic [SLOTS-1:0]           held_mask,
  output logic [$clog2(SLOTS+1)-1:0] held_count,
  output logic                       ovf,
  output logic                       tbl_full
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW = $clog2(SLOTS + 1);

  seq_state_t       state;
  seq_act_t         act;
  logic             cur_ext;
  logic [8:0]       cur_key;

  logic [SLOTS-1:0] key_valid;
  logic [8:0]       key_id [SLOTS];
  logic             hit;
  logic [SW-1:0]    hit_idx;
  logic             free_found;
  logic [SW-1:0]    free_idx;

  logic             push_q;
  key_evt_t         evt_q;
  key_evt_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // Table lookup of the incoming byte: matching slot and lowest free slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    cur_ext    = (state == S_EXT) || (state == S_EXT_BRK);
    cur_key    = {cur_ext, bus.byte_data};
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    // Scanning downward lets the lowest index win.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (key_valid[i] && (key_id[i] == cur_key)) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
      if (!key_valid[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  // Classify a terminating byte by the prefix state it arrives in.
  always_comb begin
    act = ACT_NONE;
    if (bus.byte_valid && !is_prefix(bus.byte_data)) begin
      unique case (state)
        S_IDLE:
          act = ((bus.byte_data == SC_BAT) || (bus.byte_data == SC_BATERR))
                ? ACT_CLEAR : ACT_MAKE;
        S_EXT:            act = ACT_MAKE;
        S_BRK, S_EXT_BRK: act = ACT_BREAK;
        default:          act = ACT_NONE;
      endcase
    end
  end

  // Prefix FSM, slot occupancy, registered event push and tbl_full flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      key_valid <= '0;
      push_q    <= 1'b0;
      evt_q     <= '0;
      tbl_full  <= 1'b0;
    end else begin
      push_q <= 1'b0;

      if (bus.byte_valid) begin
        unique case (state)
          S_IDLE: begin
            if (bus.byte_data == SC_EXT)      state <= S_EXT;
            else if (bus.byte_data == SC_BRK) state <= S_BRK;
          end
          S_EXT: begin
            if (bus.byte_data == SC_BRK)      state <= S_EXT_BRK;
            else if (bus.byte_data != SC_EXT) state <= S_IDLE;
          end
          // A second prefix after F0 is malformed: drop back to idle.
          S_BRK, S_EXT_BRK: state <= S_IDLE;
          default:          state <= S_IDLE;
        endcase
      end

      if (act != ACT_NONE) begin
        evt_q.code <= bus.byte_data;
        evt_q.ext  <= cur_ext;
        evt_q.make <= (act == ACT_MAKE);
      end

      unique case (act)
        ACT_MAKE: begin
          if (hit) begin
`ifdef PS2_TYPEMATIC_EN
            push_q <= 1'b1;
`else
            push_q <= 1'b0;
`endif
          end else begin
            push_q <= 1'b1;
            if (free_found) key_valid[free_idx] <= 1'b1;
            else            tbl_full            <= 1'b1;
          end
        end
        ACT_BREAK: begin
          push_q <= 1'b1;
          if (hit) key_valid[hit_idx] <= 1'b0;
        end
        ACT_CLEAR: key_valid <= '0;
        default:   ;
      endcase
    end
  end

  // Key identity of each slot; only meaningful while its valid bit is set.
  always_ff @(posedge Clk) begin
    if ((act == ACT_MAKE) && !hit && free_found) key_id[free_idx] <= cur_key;
  end

  // Occupied-slot count.
  always_comb begin
    held_count = '0;
    for (int i = 0; i < SLOTS; i++) held_count = held_count + CW'(key_valid[i]);
  end

  assign held_mask = key_valid;

  assign pop = ~fifo_empty & bus.evt_ready;

  ps2_evt_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push_q),
    .din   (evt_q),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: an event arrived at a full queue with nothing leaving.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                            ovf <= 1'b0;
    else if (push_q && fifo_full && !pop) ovf <= 1'b1;
  end

  assign bus.evt_valid = ~fifo_empty;
  assign bus.evt_code  = head.code;
  assign bus.evt_ext   = head.ext;
  assign bus.evt_make  = head.make;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: a behavioural model derives the
// expected events and held-key table from each byte; a separate monitor
// pops the expected queue whenever the DUT hands over an event.
module tb_ps2_key_sequencer;
  import ps2_pkg::*;

  localparam int SLOTS  = 6;
  localparam int QDEPTH = 4;
  localparam int CW     = $clog2(SLOTS + 1);

  logic             Clk   = 1'b0;
  logic             Reset = 1'b1;
  logic [SLOTS-1:0] held_mask;
  logic [CW-1:0]    held_count;
  logic             ovf;
  logic             tbl_full;

  ps2_key_sequencer_if bus ();

  ps2_key_sequencer #(
    .SLOTS  (SLOTS),
    .QDEPTH (QDEPTH)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus),
    .held_mask  (held_mask),
    .held_count (held_count),
    .ovf        (ovf),
    .tbl_full   (tbl_full)
  );

  always #5 Clk = ~Clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  key_evt_t exp_q[$];
  int       slot_key [SLOTS];   // -1 = empty, else {ext,code}
  bit       m_ext, m_brk, m_ovf, m_tblf;
  bit       pend_v;
  key_evt_t pend_e;

  function automatic void model_reset();
    for (int i = 0; i < SLOTS; i++) slot_key[i] = -1;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_tblf = 0; pend_v = 0;
    exp_q.delete();
  endfunction

  function automatic logic [SLOTS-1:0] model_mask();
    logic [SLOTS-1:0] m = '0;
    for (int i = 0; i < SLOTS; i++) m[i] = (slot_key[i] >= 0);
    return m;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (slot_key[i] >= 0) n++;
    return n;
  endfunction

  function automatic int find_key(input int key);
    for (int i = 0; i < SLOTS; i++) if (slot_key[i] == key) return i;
    return -1;
  endfunction

  function automatic void model_make(input logic [7:0] c, input bit x);
    int key = (int'(x) << 8) | int'(c);
    int fr  = -1;
    if (find_key(key) >= 0) begin
`ifdef PS2_TYPEMATIC_EN
      pend_v = 1; pend_e = '{code: c, ext: x, make: 1'b1};
`endif
      return;
    end
    pend_v = 1; pend_e = '{code: c, ext: x, make: 1'b1};
    for (int i = SLOTS - 1; i >= 0; i--) if (slot_key[i] < 0) fr = i;
    if (fr >= 0) slot_key[fr] = key;
    else         m_tblf = 1;
  endfunction

  function automatic void model_break(input logic [7:0] c, input bit x);
    int idx = find_key((int'(x) << 8) | int'(c));
    pend_v = 1; pend_e = '{code: c, ext: x, make: 1'b0};
    if (idx >= 0) slot_key[idx] = -1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk)          begin m_ext = 0; m_brk = 0; end
      else if (b == 8'hF0) m_brk = 1;
      else                 m_ext = 1;
    end else begin
      if (m_brk) model_break(b, m_ext);
      else if (!m_ext && (b == 8'hAA || b == 8'hFC))
        for (int i = 0; i < SLOTS; i++) slot_key[i] = -1;
      else model_make(b, m_ext);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Model step for the coming rising edge; inputs change only at posedge+2.
  always @(negedge Clk) begin
    if (Reset) begin
      model_reset();
      check("reset evt_valid", bus.evt_valid, 0);
      check("reset evt_head", {bus.evt_code, bus.evt_ext, bus.evt_make}, 0);
      check("reset held_mask", held_mask, 0);
      check("reset flags", {ovf, tbl_full, held_count}, 0);
    end else begin
      check("held_mask", held_mask, model_mask());
      check("held_count", held_count, model_count());
      check("ovf", ovf, m_ovf);
      check("tbl_full", tbl_full, m_tblf);
      if (pend_v) begin
        if (exp_q.size() < QDEPTH || (bus.evt_ready && exp_q.size() > 0))
          exp_q.push_back(pend_e);
        else
          m_ovf = 1;
        pend_v = 0;
      end
      if (bus.byte_valid) model_byte(bus.byte_data);
    end
  end

  // ---------------- monitor ----------------
  int       evt_pops = 0;
  key_evt_t last_evt;

  always @(negedge Clk) begin
    key_evt_t e;
    #1;
    if (!Reset && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("evt_code", bus.evt_code, e.code);
        check("evt_ext", bus.evt_ext, e.ext);
        check("evt_make", bus.evt_make, e.make);
      end
      last_evt = '{code: bus.evt_code, ext: bus.evt_ext, make: bus.evt_make};
      evt_pops++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge Clk); #2;
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [13];

  initial begin
    int p0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.evt_ready  = 1'b0;
    pool = '{8'hE0, 8'hF0, 8'hAA, 8'hFC, 8'h1C, 8'h1D, 8'h1E,
             8'h75, 8'h6B, 8'h2A, 8'h29, 8'h15, 8'h24};
    idle(2);
    Reset = 1'b0;
    idle(1);

    // Plain make then break.
    bus.evt_ready = 1'b1;
    p0 = evt_pops;
    send(8'h1C);
    check("t1 count after make", held_count, 1);
    send(8'hF0); send(8'h1C);
    check("t1 count after break", held_count, 0);
    idle(3);
    check("t1 events", evt_pops - p0, 2);

    // Extended key plus plain key of the same code.
    send(8'hE0); send(8'h75); send(8'h75);
    check("t2 two slots", held_count, 2);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2 after ext break", held_count, 1);
    check("t2 plain 75 slot", held_mask, 6'b000010);
    idle(3);

    // Typematic repeat.
    do_reset();
    p0 = evt_pops;
    send(8'h1C); send(8'h1C); send(8'h1C);
    idle(4);
    check("t3 held_count", held_count, 1);
`ifdef PS2_TYPEMATIC_EN
    check("t3 repeats", evt_pops - p0, 3);
`else
    check("t3 repeats", evt_pops - p0, 1);
`endif

    // Queue overflow.
    do_reset();
    bus.evt_ready = 1'b0;
    p0 = evt_pops;
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    idle(3);
    check("t4 ovf", ovf, 1);
    check("t4 evt_valid held", bus.evt_valid, 1);
    bus.evt_ready = 1'b1;
    idle(8);
    check("t4 drained", evt_pops - p0, 4);
    check("t4 empty", bus.evt_valid, 0);

    // Table full then BAT clear.
    do_reset();
    p0 = evt_pops;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
    send(8'h2A);
    idle(3);
    check("t5 tbl_full", tbl_full, 1);
    check("t5 held_count", held_count, 6);
    check("t5 events", evt_pops - p0, 7);
    send(8'hAA);
    idle(3);
    check("t5 mask cleared", held_mask, 0);
    check("t5 no bat event", evt_pops - p0, 7);

    // Reset in the middle of an E0 sequence.
    send(8'hE0);
    do_reset();
    p0 = evt_pops;
    send(8'h1C);
    idle(3);
    check("t6 events", evt_pops - p0, 1);
    check("t6 event", last_evt, {8'h1C, 1'b0, 1'b1});

    // Randomised traffic with occasional resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) do_reset();
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) send(pool[$urandom_range(0, 12)]);
      else                           idle(1);
    end

    // Bounded drain of whatever is still queued.
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || pend_v || bus.evt_valid); i++) idle(1);
    check("drain model queue", exp_q.size(), 0);
    check("drain evt_valid", bus.evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Controller between the PS/2 serial byte receiver and game logic.
- Consumes the raw scan-code byte stream and sequences the multi-byte prefixes (E0 extended, F0 break) through an FSM.
- Maintains a table of currently held keys and delivers decoded make/break events through a small valid/ready event queue.
- Removes the need for the consumer to do ad-hoc comparison of two adjacent shift-register frames.

Parameters:
- SLOTS, 6: number of simultaneously tracked held keys (1..8).
- QDEPTH, 4: event queue depth; must be a power of two, 2..16.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a complete received scan byte
- byte_data  in  8  received scan byte
- evt_valid  out  1  event queue not empty
- evt_ready  in  1  consumer accepts the head event this cycle
- evt_code  out  8  head event scan code
- evt_ext  out  1  head event came from an E0-prefixed sequence
- evt_make  out  1  1 = press, 0 = release
- held_mask  out  SLOTS  per-slot occupied bits
- held_count  out  $clog2(SLOTS+1)  number of occupied slots
- ovf  out  1  sticky: event dropped because the queue was full
- tbl_full  out  1  sticky: make event arrived with no free slot

Behaviour:
- Interface: Clk is the clock; Reset is asynchronous, active-high. On Reset:
  - FSM goes to S_IDLE.
  - Table and queue are cleared.
  - evt_valid=0; evt_code/evt_ext/evt_make=0.
  - held_mask=0, held_count=0, ovf=0, tbl_full=0.
- All state updates occur on posedge Clk. byte_data is sampled only when byte_valid=1.
- FSM states and transitions on a valid byte:
  - S_IDLE:
    - E0 -> S_EXT
    - F0 -> S_BRK
    - AA or FC (BAT result) -> clear table, no event, stay in S_IDLE
    - anything else -> make(code, ext=0), stay in S_IDLE
  - S_EXT:
    - F0 -> S_EXT_BRK
    - E0 -> stay in S_EXT
    - else -> make(code, ext=1), go to S_IDLE
  - S_BRK:
    - F0/E0 -> go to S_IDLE, discarding the malformed sequence
    - else -> break(code, ext=0), go to S_IDLE
  - S_EXT_BRK: any byte except F0/E0 -> break(code, ext=1), go to S_IDLE; F0/E0 -> go to S_IDLE, discard.
- make(c, x):
  - If {x,c} is already in the table, it is a typematic repeat; see the optional feature.
  - Else insert into the lowest-index free slot and enqueue {c, x, make=1}.
  - If no free slot: enqueue the event anyway, do not insert, set tbl_full.
- break(c, x):
  - If {x,c} is in the table: clear that slot and enqueue {c, x, make=0}.
  - If not in the table: enqueue anyway; the table is unchanged.
- Table match is on the 9-bit {ext,code}. held_mask and held_count update the cycle after byte_valid.
- Event latency: byte_valid on the final byte at edge N gives evt_valid=1 after edge N+1 when the queue was empty. The queue is first-word fall-through.
- Handshake:
  - A pop occurs when evt_valid & evt_ready.
  - evt_ready while empty is ignored.
  - Outputs are stable while evt_valid=1 and evt_ready=0.
- Simultaneous push and pop on a full queue: the pop frees space, so the push succeeds and there is no ovf.
- Push while full with no pop: the new event is dropped, the queue is unchanged, and ovf sets.
- ovf and tbl_full clear only on Reset.
- Pointers are $clog2(QDEPTH) bits and wrap naturally; the count is $clog2(QDEPTH)+1 bits.
- byte_valid pulses on consecutive cycles are all processed; there are no stalls.

Optional Feature:
- Macro: PS2_TYPEMATIC_EN.
- Defined: a typematic repeat (make for a key already held) enqueues {c, x, make=1} again, so the consumer sees auto-repeat.
- Undefined: repeats are silently suppressed; only the first make per press reaches the queue.

Decomposition:
- Package ps2_pkg:
  - localparams SC_EXT=8'hE0, SC_BRK=8'hF0, SC_BAT=8'hAA, SC_BATERR=8'hFC.
  - Enum seq_state_t {S_IDLE, S_EXT, S_BRK, S_EXT_BRK}.
  - Packed struct key_evt_t {logic [7:0] code; logic ext; logic make;}.
- One sub-module: ps2_evt_fifo, a parameterised FWFT queue of key_evt_t with push/pop/full/empty. The FSM and key table stay in ps2_key_sequencer.

Test Plan:
- Bytes 1C, F0 1C with evt_ready=1: events {1C,ext0,make1} then {1C,ext0,make0}; held_count goes 1 then 0.
- Bytes E0 75, E0 F0 75: events {75,ext1,make1} then {75,ext1,make0}. A plain 75 make in between occupies a separate slot (held_count=2).
- Bytes 1C 1C 1C with evt_ready=1: one event without PS2_TYPEMATIC_EN, three with it; held_count=1 either way.
- With evt_ready=0, send 5 makes (QDEPTH=4): the first 4 are queued in order and ovf=1. Asserting evt_ready then drains exactly 4 events.
- Fill 6 slots, then make 2A: event emitted, tbl_full=1, held_count stays 6. Then bytes AA: held_mask=0, no event.
- Reset asserted mid-sequence (after E0) then released; then byte 1C: event {1C,ext0,make1}, confirming the FSM returned to S_IDLE.
